// File: rtl/udp_core8_pkg.sv
// Shared constants for the byte-serial ARP encoder/decoder pair.
// Provides fixed ARP header values, per-field byte offsets and the decoder state type.
package udp_core8_pkg;

    // Fixed ARP header values for Ethernet/IPv4.
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam int          ARP_BYTES      = 28;

    // Byte offsets of each field within the ARP payload.
    localparam logic [4:0] ARP_OFF_HTYPE = 5'd0;
    localparam logic [4:0] ARP_OFF_PTYPE = 5'd2;
    localparam logic [4:0] ARP_OFF_HLEN  = 5'd4;
    localparam logic [4:0] ARP_OFF_PLEN  = 5'd5;
    localparam logic [4:0] ARP_OFF_OPER  = 5'd6;
    localparam logic [4:0] ARP_OFF_SHA   = 5'd8;
    localparam logic [4:0] ARP_OFF_SPA   = 5'd14;
    localparam logic [4:0] ARP_OFF_THA   = 5'd18;
    localparam logic [4:0] ARP_OFF_TPA   = 5'd24;

    typedef enum logic [1:0] {
        ARP_PARSE = 2'd0,
        ARP_DONE  = 2'd1,
        ARP_IDLE  = 2'd2
    } arp_dec_state_e;

    // Returns {check_enable, expected_byte} for a payload index.
    // Only the fixed header bytes (0..5) are checked.
    function automatic logic [8:0] arp_hdr_expect(input logic [4:0] idx);
        logic [8:0] r;
        r = 9'd0;
        case (idx)
            ARP_OFF_HTYPE:        r = {1'b1, ARP_HTYPE_ETH[15:8]};
            ARP_OFF_HTYPE + 5'd1: r = {1'b1, ARP_HTYPE_ETH[7:0]};
            ARP_OFF_PTYPE:        r = {1'b1, ETHERTYPE_IPV4[15:8]};
            ARP_OFF_PTYPE + 5'd1: r = {1'b1, ETHERTYPE_IPV4[7:0]};
            ARP_OFF_HLEN:         r = {1'b1, ARP_HLEN};
            ARP_OFF_PLEN:         r = {1'b1, ARP_PLEN};
            default:              r = 9'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arp_decode8.sv
// Byte-serial ARP payload parser: checks the fixed header, extracts opcode/SHA/SPA/THA/TPA.
// Ports: clk, sync_reset, run, data_in, local_ip in; field outputs, done, valid, is_request_for_us, error out.
module arp_decode8 #(
    parameter int AVL_SIZE  = 8,
    parameter int ARP_BYTES = 28,
    parameter int MAC_SIZE  = 48,
    parameter int IP_SIZE   = 32
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                run,
    input  logic [AVL_SIZE-1:0] data_in,
    input  logic [IP_SIZE-1:0]  local_ip,
    output logic [15:0]         opcode,
    output logic [MAC_SIZE-1:0] sender_hardware_address,
    output logic [IP_SIZE-1:0]  sender_protocol_address,
    output logic [MAC_SIZE-1:0] target_hardware_address,
    output logic [IP_SIZE-1:0]  target_protocol_address,
    output logic                done,
    output logic                valid,
    output logic                is_request_for_us,
    output logic                error
);
    import udp_core8_pkg::*;

    localparam logic [4:0] IDX_LAST = 5'(ARP_BYTES - 1);
    localparam logic [4:0] IDX_SAT  = 5'(ARP_BYTES);

    arp_dec_state_e state_q, state_d;

    logic [4:0]          idx_q, idx_d;
    logic [15:0]         op_q, op_d;
    logic [MAC_SIZE-1:0] sha_q, sha_d;
    logic [IP_SIZE-1:0]  spa_q, spa_d;
    logic [MAC_SIZE-1:0] tha_q, tha_d;
    logic [IP_SIZE-1:0]  tpa_q, tpa_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                rfu_q, rfu_d;
    logic                err_q, err_d;

    logic                accept;
    logic [8:0]          hdr;

    function automatic logic in_rng(
        input logic [4:0] i,
        input logic [4:0] lo,
        input logic [4:0] hi
    );
        return (i >= lo) && (i <= hi);
    endfunction

    assign accept = run && (state_q == ARP_PARSE);
    assign hdr    = arp_hdr_expect(idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        tha_d   = tha_q;
        tpa_d   = tpa_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        rfu_d   = rfu_q;
        err_d   = err_q;

        case (state_q)
            ARP_PARSE: begin
                if (accept) begin
                    if (idx_q < IDX_SAT)
                        idx_d = idx_q + 5'd1;

                    if (hdr[8] && (data_in != hdr[7:0]))
                        err_d = 1'b1;

                    if (in_rng(idx_q, ARP_OFF_OPER, ARP_OFF_SHA - 5'd1))
                        op_d = {op_q[15-AVL_SIZE:0], data_in};
                    if (in_rng(idx_q, ARP_OFF_SHA, ARP_OFF_SPA - 5'd1))
                        sha_d = {sha_q[MAC_SIZE-AVL_SIZE-1:0], data_in};
                    if (in_rng(idx_q, ARP_OFF_SPA, ARP_OFF_THA - 5'd1))
                        spa_d = {spa_q[IP_SIZE-AVL_SIZE-1:0], data_in};
                    if (in_rng(idx_q, ARP_OFF_THA, ARP_OFF_TPA - 5'd1))
                        tha_d = {tha_q[MAC_SIZE-AVL_SIZE-1:0], data_in};
                    if (in_rng(idx_q, ARP_OFF_TPA, IDX_LAST))
                        tpa_d = {tpa_q[IP_SIZE-AVL_SIZE-1:0], data_in};

                    // Verdict is registered on the edge that takes the
                    // last byte so it is visible alongside done.
                    if (idx_q == IDX_LAST) begin
                        state_d = ARP_DONE;
                        done_d  = 1'b1;
                        valid_d = !err_d &&
                                  ((op_q == ARP_OP_REQUEST) ||
                                   (op_q == ARP_OP_REPLY));
                        rfu_d   = valid_d &&
                                  (op_q == ARP_OP_REQUEST) &&
                                  (tpa_d == local_ip);
                    end
                end
            end
            ARP_DONE: begin
                state_d = ARP_IDLE;
            end
            ARP_IDLE: begin
                state_d = ARP_IDLE;
            end
            default: begin
                state_d = ARP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= ARP_PARSE;
            idx_q   <= 5'd0;
            op_q    <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tha_q   <= '0;
            tpa_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rfu_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            tha_q   <= tha_d;
            tpa_q   <= tpa_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            rfu_q   <= rfu_d;
            err_q   <= err_d;
        end
    end

    assign opcode                  = op_q;
    assign sender_hardware_address = sha_q;
    assign sender_protocol_address = spa_q;
    assign target_hardware_address = tha_q;
    assign target_protocol_address = tpa_q;
    assign done                    = done_q;
    assign valid                   = valid_q;
    assign is_request_for_us       = rfu_q;
    assign error                   = err_q;

endmodule

// File: doc/arp_decode8.md
Name: arp_decode8

Overview:
Byte-serial ARP payload parser: the receive-side counterpart of the ARP encoder in udp_core8.
- Consumes the 28-byte ARP packet one byte per `run` cycle, starting at the first byte after the Ethernet type field.
- Checks the fixed header fields, extracts opcode and the four addresses, and flags whether the packet targets our IP.
- The RX dispatcher pulses `sync_reset` before each frame; the ARP responder consumes `done`/`valid` and the address outputs.

Parameters:
AVL_SIZE, 8, input data width in bits; only 8 is supported.
ARP_BYTES, 28, ARP payload length in bytes.
MAC_SIZE, 48, hardware address width.
IP_SIZE, 32, protocol address width.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
sync_reset  in  1  synchronous, active-high; clears the block and arms it for a new frame.
run  in  1  data_in holds a valid byte this cycle.
data_in  in  AVL_SIZE  payload byte, network order (MSB byte first).
local_ip  in  IP_SIZE  our IPv4 address; static during a frame.
opcode  out  16  ARP operation field.
sender_hardware_address  out  MAC_SIZE  SHA.
sender_protocol_address  out  IP_SIZE  SPA.
target_hardware_address  out  MAC_SIZE  THA.
target_protocol_address  out  IP_SIZE  TPA.
done  out  1  one-cycle pulse when the 28th byte has been processed.
valid  out  1  header checks passed; qualified by done, held until reset.
is_request_for_us  out  1  valid && opcode==1 && TPA==local_ip; held until reset.
error  out  1  a fixed-field mismatch was seen; sticky until reset.

Behaviour:
- Reset: the byte counter `idx`, every address field, `opcode`, `done`, `valid`, `is_request_for_us` and `error` all go to 0. The state machine enters PARSE.
- States:
  - PARSE → DONE on the run cycle where idx==27.
  - DONE → IDLE after one cycle.
  - IDLE stays until sync_reset.
  - sync_reset from any state → PARSE, including mid-frame. A partial frame is discarded and no done is emitted.
- In PARSE, each run cycle consumes data_in at position idx and then increments idx; run=0 cycles hold all state. Gaps of any length are legal.
- Byte map and checks:
  - idx 0-1 HTYPE: must equal 0x0001.
  - idx 2-3 PTYPE: must equal 0x0800.
  - idx 4 HLEN: must equal 0x06.
  - idx 5 PLEN: must equal 0x04.
  - idx 6-7: opcode.
  - idx 8-13: SHA.
  - idx 14-17: SPA.
  - idx 18-23: THA.
  - idx 24-27: TPA.
  - Each field is filled by shift-left-insert at its own index range.
- Any mismatch at idx 0-5 sets `error`. Parsing continues to idx 27 so that done is still produced for frame-level bookkeeping.
- On the clock edge that accepts byte 27, the next state is DONE, and all field outputs are already final in that same cycle.
- DONE cycle:
  - done=1.
  - valid = !error && (opcode==1 || opcode==2).
  - is_request_for_us is computed combinationally from the final fields and registered in the same cycle.
- Latency: each field output updates 1 clk after its last byte is accepted. done asserts 1 clk after the 28th accepted byte.
- In DONE and IDLE, run bytes (Ethernet padding or FCS) are ignored. Outputs, valid, error and is_request_for_us hold until sync_reset.
- A run byte on the same cycle as sync_reset is discarded; reset wins.
- idx is 5 bits and saturates at 28; it never wraps.

Decomposition:
- Shared package `udp_core8_pkg`:
  - constants ARP_HTYPE_ETH=16'h0001, ETHERTYPE_IPV4=16'h0800, ARP_HLEN=8'h06, ARP_PLEN=8'h04, ARP_OP_REQUEST=16'h0001, ARP_OP_REPLY=16'h0002, ARP_BYTES=28;
  - the byte-offset constants for each field, shared with arp_encode8.
- No sub-module is needed; a single flat module of roughly 150-200 lines.

Test Plan:
- Request 0001 0800 06 04 0001, SHA=00:11:22:33:44:55, SPA=192.168.1.10, THA=0, TPA=192.168.1.2, local_ip=192.168.1.2, run continuous → done 1 clk after byte 27; valid=1, is_request_for_us=1, error=0; fields match exactly.
- Same frame but with opcode 0002 and TPA=192.168.1.99 → valid=1, is_request_for_us=0, opcode=0x0002.
- HTYPE=0x0006 → error=1 from the cycle after byte 1; done still pulses; valid=0, is_request_for_us=0.
- Valid request with run deasserted for 3 cycles after every 4th byte → identical outputs to the first scenario; done timing is 1 clk after the last accepted byte.
- sync_reset asserted after byte 15, then a full new valid frame → no done for the partial frame; the second frame decodes correctly, with all fields cleared at reset.
- Valid frame followed by 18 padding bytes of 0xAA with run=1 → exactly one done pulse; outputs unchanged by the padding.
